aes_block_sequencer: RTL and testbench
======================================

# aes_block_sequencer

Front-end sequencer for the 32-bit-word AES-128 core. It accepts a full 128-bit key and plaintext through a valid/ready handshake and serialises them into the core's word interface with the start strobe. It waits for core completion, issues the read strobe, reassembles the four ciphertext words into a 128-bit result and returns it through a second valid/ready handshake. A watchdog flags a core that never reports done.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1024: maximum cycles spent in WAIT_DONE before abort; must be ≥ 1.
- READ_LATENCY, 1: cycles from the aes_start_read_n low cycle to the first valid aes_dword_out word; range 0–3.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  key/plaintext offered.
- in_ready  out  1  sequencer idle, can accept.
- in_key  in  128  cipher key; word 0 = [127:96].
- in_pt  in  128  plaintext; word 0 = [127:96].
- out_valid  out  1  ciphertext available.
- out_ready  in  1  consumer accepts ciphertext.
- out_ct  out  128  ciphertext; word 0 = [127:96].
- busy  out  1  high in every state except IDLE.
- timeout_err  out  1  sticky watchdog flag.
- aes_start_n  out  1  core write-start strobe, active low.
- aes_start_read_n  out  1  core read-start strobe, active low.
- aes_dword_in  out  32  word driven to the core.
- aes_dword_out  in  32  word returned from the core.
- aes_done  in  1  core completion flag.

## Operation
- States: IDLE, LOAD_PT, LOAD_KEY, WAIT_DONE, READ_REQ, READ, OUT.
- Reset values: state IDLE, in_ready 0 while reset is high, out_valid 0, out_ct 0, busy 0, timeout_err 0, aes_start_n 1, aes_start_read_n 1, aes_dword_in 0.
- in_ready is (state==IDLE) && !reset. in_valid is ignored in every other state.
- On acceptance, in_key and in_pt are latched. timeout_err clears. Next state is LOAD_PT.
- LOAD_PT: 4 cycles driving plaintext words 0..3. aes_start_n is low on the word-0 cycle only.
- LOAD_KEY: 4 cycles driving key words 0..3. Next state is WAIT_DONE.
- aes_dword_in is 0 outside LOAD_PT and LOAD_KEY.
- WAIT_DONE: a 16-bit watchdog counter increments each cycle.
  - aes_done high moves to READ_REQ.
  - If the counter reaches TIMEOUT_CYCLES−1 with aes_done low: timeout_err is set, next state is IDLE, out_valid is never raised.
  - If aes_done and the timeout hit occur in the same cycle, aes_done wins.
- READ_REQ: one cycle with aes_start_read_n low. Next state is READ.
- READ: wait READ_LATENCY−1 further cycles, then capture aes_dword_out on 4 consecutive cycles into words 0..3. Next state is OUT.
- OUT: out_valid is high. out_ct is stable until accepted. On out_valid && out_ready, next state is IDLE and out_valid drops the next cycle.
- Reset mid-operation: return to IDLE with all reset values. Partial data is discarded and no out_valid is raised.

## Timing
- Input accepted at cycle T.
- aes_start_n low and plaintext word 0 at T+1.
- Plaintext words 1..3 at T+2..T+4. Key words 0..3 at T+5..T+8.
- WAIT_DONE starts at T+9.
- aes_done first sampled high at cycle D: aes_start_read_n low at D+1.
- Words 0..3 captured at D+1+READ_LATENCY .. D+4+READ_LATENCY.
- out_valid high at D+5+READ_LATENCY.
- out_valid falls, and in_ready rises, the cycle after out_ready is high with out_valid high.
- Minimum input-to-output latency with aes_done at T+9 and READ_LATENCY=1: 15 cycles.
- Watchdog abort: in_ready high at T+9+TIMEOUT_CYCLES.
- No back-to-back overlap: one block in flight.

## Structure
- Package aes_seq_pkg holds:
  - the state enum typedef;
  - WORDS_PER_BLOCK = 4;
  - WORD_W = 32;
  - a word-select function returning word i of a 128-bit vector (i = 0 selects [127:96]).
- One sub-module, aes_ct_packer: a 4×32 capture register with capture-enable and a 2-bit word index, outputting the 128-bit packed vector. It is shared with the read path. Everything else lives in aes_block_sequencer.

## Test plan
- FIPS-197 C.1 vector (default parameters): in_key 000102030405060708090a0b0c0d0e0f, in_pt 00112233445566778899aabbccddeeff. The behavioural core returns ct 69c4e0d86a7b0430d8cdb78070b4c55a → out_ct equals it. Word order on aes_dword_in is 00112233, 44556677, 8899aabb, ccddeeff, 00010203, 04050607, 08090a0b, 0c0d0e0f.
- Strobe timing: aes_done at T+9, READ_LATENCY=1 → aes_start_n low only at T+1, aes_start_read_n low only at T+10, out_valid at T+15.
- Backpressure: out_ready held low for 20 cycles → out_ct stable, in_ready stays 0, a pending in_valid is not accepted. out_valid drops one cycle after out_ready rises.
- Watchdog: TIMEOUT_CYCLES=8, aes_done never asserted → timeout_err=1, no out_valid, in_ready=1 at T+17. The next accepted block clears timeout_err.
- Tie: aes_done and the timeout terminal count in the same cycle → READ_REQ taken, timeout_err stays 0.
- Reset pulse during LOAD_KEY, then release → in_ready=1, out_valid=0, aes_start_n=1. A fresh vector completes correctly.

Source files
------------

// File: rtl/aes_seq_pkg.sv
// Shared types and helpers for the AES block sequencer and its ciphertext packer.
package aes_seq_pkg;

  localparam int WORDS_PER_BLOCK = 4;
  localparam int WORD_W          = 32;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD_PT   = 3'd1,
    S_LOAD_KEY  = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_READ_REQ  = 3'd4,
    S_READ      = 3'd5,
    S_OUT       = 3'd6
  } state_t;

  // Word 0 is the most significant word of the block.
  function automatic logic [WORD_W-1:0] word_sel(
    input logic [WORDS_PER_BLOCK*WORD_W-1:0] vec,
    input logic [1:0]                        idx
  );
    logic [WORD_W-1:0] w;
    case (idx)
      2'd0:    w = vec[127:96];
      2'd1:    w = vec[95:64];
      2'd2:    w = vec[63:32];
      default: w = vec[31:0];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/aes_ct_packer.sv
// Four-word capture register that assembles core output words into a 128-bit block.
module aes_ct_packer
  import aes_seq_pkg::*;
(
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              i_cap_en,
  input  logic [1:0]                        i_idx,
  input  logic [WORD_W-1:0]                 i_word,
  output logic [WORDS_PER_BLOCK*WORD_W-1:0] o_vec
);

  logic [WORD_W-1:0] r_words [WORDS_PER_BLOCK];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WORDS_PER_BLOCK; i++) r_words[i] <= '0;
    end else if (i_cap_en) begin
      r_words[i_idx] <= i_word;
    end
  end

  assign o_vec = {r_words[0], r_words[1], r_words[2], r_words[3]};

endmodule

// File: rtl/aes_block_sequencer.sv
// Serialises a 128-bit key/plaintext into the word-wide AES core, waits for completion
// under a watchdog, and returns the reassembled ciphertext through a valid/ready port.
module aes_block_sequencer
  import aes_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int READ_LATENCY   = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_key,
  input  logic [127:0] in_pt,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_ct,
  output logic         busy,
  output logic         timeout_err,
  output logic         aes_start_n,
  output logic         aes_start_read_n,
  output logic [31:0]  aes_dword_in,
  input  logic [31:0]  aes_dword_out,
  input  logic         aes_done
);

  localparam logic [15:0] WD_LAST  = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]  RD_FIRST = 3'(READ_LATENCY);
  localparam logic [2:0]  RD_LAST  = 3'(READ_LATENCY + 3);

  state_t       r_state;
  logic [127:0] r_key;
  logic [127:0] r_pt;
  logic [1:0]   r_ld_idx;
  logic [2:0]   r_rd_cnt;
  logic [15:0]  r_wd_cnt;
  logic         r_timeout_err;

  logic         w_accept;
  logic         w_cap_en;
  logic [1:0]   w_cap_idx;

  assign in_ready = (r_state == S_IDLE) && !reset;
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_ld_idx      <= '0;
      r_rd_cnt      <= '0;
      r_wd_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state       <= S_LOAD_PT;
            r_ld_idx      <= '0;
            r_timeout_err <= 1'b0;
          end
        end
        S_LOAD_PT: begin
          r_ld_idx <= r_ld_idx + 2'd1;
          if (r_ld_idx == 2'd3) r_state <= S_LOAD_KEY;
        end
        S_LOAD_KEY: begin
          r_ld_idx <= r_ld_idx + 2'd1;
          if (r_ld_idx == 2'd3) begin
            r_state  <= S_WAIT_DONE;
            r_wd_cnt <= '0;
          end
        end
        S_WAIT_DONE: begin
          r_wd_cnt <= r_wd_cnt + 16'd1;
          // A done arriving on the terminal count still completes the block.
          if (aes_done) begin
            r_state  <= S_READ_REQ;
            r_rd_cnt <= '0;
          end else if (r_wd_cnt == WD_LAST) begin
            r_state       <= S_IDLE;
            r_timeout_err <= 1'b1;
          end
        end
        S_READ_REQ: begin
          r_rd_cnt <= r_rd_cnt + 3'd1;
          r_state  <= S_READ;
        end
        S_READ: begin
          r_rd_cnt <= r_rd_cnt + 3'd1;
          if (r_rd_cnt == RD_LAST) r_state <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_key <= in_key;
      r_pt  <= in_pt;
    end
  end

  // r_rd_cnt counts from the read-strobe cycle, so capture starts READ_LATENCY later.
  assign w_cap_en  = ((r_state == S_READ_REQ) || (r_state == S_READ)) &&
                     (r_rd_cnt >= RD_FIRST) && (r_rd_cnt <= RD_LAST);
  assign w_cap_idx = 2'(r_rd_cnt - RD_FIRST);

  aes_ct_packer u_packer (
    .clk      (clk),
    .reset    (reset),
    .i_cap_en (w_cap_en),
    .i_idx    (w_cap_idx),
    .i_word   (aes_dword_out),
    .o_vec    (out_ct)
  );

  always_comb begin
    aes_dword_in = '0;
    case (r_state)
      S_LOAD_PT:  aes_dword_in = word_sel(r_pt, r_ld_idx);
      S_LOAD_KEY: aes_dword_in = word_sel(r_key, r_ld_idx);
      default:    aes_dword_in = '0;
    endcase
  end

  assign aes_start_n      = !((r_state == S_LOAD_PT) && (r_ld_idx == 2'd0));
  assign aes_start_read_n = (r_state != S_READ_REQ);
  assign out_valid        = (r_state == S_OUT);
  assign busy             = (r_state != S_IDLE);
  assign timeout_err      = r_timeout_err;

endmodule

// File: tb/tb_aes_block_sequencer.sv
// Bench for aes_block_sequencer: behavioural AES core stand-in, vector table, random blocks,
// and hand-written reset/backpressure sequences.
module tb_aes_block_sequencer;

  localparam int TO = 8;
  localparam int RL = 1;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_key = '0;
  logic [127:0] in_pt = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_ct;
  logic         busy;
  logic         timeout_err;
  logic         aes_start_n;
  logic         aes_start_read_n;
  logic [31:0]  aes_dword_in;
  logic [31:0]  aes_dword_out = '0;
  logic         aes_done = 1'b0;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  // Core stand-in state
  bit           done_arm = 1'b0;
  int           done_at = 0;
  logic [31:0]  core_w [8];
  int           wr_cnt = 0;
  logic [127:0] core_ct = '0;
  int           rd_at = -100;

  aes_block_sequencer #(.TIMEOUT_CYCLES(TO), .READ_LATENCY(RL)) dut (
    .clk              (clk),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_key           (in_key),
    .in_pt            (in_pt),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_ct           (out_ct),
    .busy             (busy),
    .timeout_err      (timeout_err),
    .aes_start_n      (aes_start_n),
    .aes_start_read_n (aes_start_read_n),
    .aes_dword_in     (aes_dword_in),
    .aes_dword_out    (aes_dword_out),
    .aes_done         (aes_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in cipher: the FIPS-197 C.1 answer for that vector, a keyed rotation otherwise.
  function automatic logic [127:0] model_ct(input logic [127:0] k, input logic [127:0] p);
    if (k == FIPS_KEY && p == FIPS_PT) return FIPS_CT;
    return {p[95:0], p[127:96]} ^ k ^ 128'h5a5a_0f0f_c3c3_1234_a5a5_f0f0_3c3c_8765;
  endfunction

  function automatic logic [31:0] wd(input logic [127:0] v, input int i);
    return v[127-32*i -: 32];
  endfunction

  // Core behaviour, evaluated mid-cycle: drive this cycle's inputs, then observe strobes.
  always @(negedge clk) begin
    aes_done = done_arm && (cyc == done_at);
    if (cyc >= rd_at && cyc < rd_at + 4) aes_dword_out = wd(core_ct, cyc - rd_at);
    else aes_dword_out = 32'hdead0000 ^ 32'(cyc);
    if (aes_start_n === 1'b0) begin
      core_w[0] = aes_dword_in;
      wr_cnt = 1;
    end else if (wr_cnt >= 1 && wr_cnt < 8) begin
      core_w[wr_cnt] = aes_dword_in;
      wr_cnt++;
      if (wr_cnt == 8)
        core_ct = model_ct({core_w[4], core_w[5], core_w[6], core_w[7]},
                           {core_w[0], core_w[1], core_w[2], core_w[3]});
    end
    if (aes_start_read_n === 1'b0) rd_at = cyc + RL;
  end

  task automatic chk_v(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One block end to end. dly: cycles after the last key word until aes_done (0 = never).
  task automatic run_block(input string tag, input logic [127:0] key, input logic [127:0] pt,
                           input logic [127:0] exp_ct, input int dly, input int hold);
    int t, w, n_start, start_cyc, n_rd, rd_cyc, ov_cyc, end_cyc, bad_w, bad_hold;
    bit expect_to;
    logic [31:0] exp_w;
    expect_to = (dly == 0) || (dly > TO);
    done_arm = 1'b0;
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk_v({tag, ".ready_before_accept"}, in_ready, 1'b1);
    in_key = key;
    in_pt = pt;
    in_valid = 1'b1;
    t = cyc;
    done_at = t + 8 + dly;
    done_arm = (dly != 0);
    @(negedge clk);
    in_valid = 1'b0;
    n_start = 0; start_cyc = -1; n_rd = 0; rd_cyc = -1; ov_cyc = -1; end_cyc = -1; bad_w = 0;
    for (int k = 1; k <= 60; k++) begin
      if (k >= 1 && k <= 4) exp_w = wd(pt, k - 1);
      else if (k >= 5 && k <= 8) exp_w = wd(key, k - 5);
      else exp_w = 32'h0;
      if (aes_dword_in !== exp_w) bad_w++;
      if (aes_start_n === 1'b0) begin n_start++; start_cyc = cyc; end
      if (aes_start_read_n === 1'b0) begin n_rd++; rd_cyc = cyc; end
      if (out_valid === 1'b1) begin ov_cyc = cyc; break; end
      if (in_ready === 1'b1) begin end_cyc = cyc; break; end
      @(negedge clk);
    end
    chk_i({tag, ".dword_in_mismatches"}, bad_w, 0);
    chk_i({tag, ".start_n_count"}, n_start, 1);
    chk_i({tag, ".start_n_cycle"}, start_cyc - t, 1);
    if (expect_to) begin
      chk_i({tag, ".read_strobe_count"}, n_rd, 0);
      chk_i({tag, ".out_valid_cycle"}, ov_cyc, -1);
      chk_i({tag, ".idle_after_timeout_cycle"}, end_cyc - t, 9 + TO);
      chk_v({tag, ".timeout_err"}, timeout_err, 1'b1);
    end else begin
      chk_i({tag, ".read_strobe_count"}, n_rd, 1);
      chk_i({tag, ".read_strobe_cycle"}, rd_cyc - t, 9 + dly);
      chk_i({tag, ".out_valid_cycle"}, ov_cyc - t, 14 + dly);
      chk_v({tag, ".out_ct"}, out_ct, exp_ct);
      chk_v({tag, ".timeout_err"}, timeout_err, 1'b0);
      bad_hold = 0;
      for (int h = 0; h < hold; h++) begin
        in_valid = 1'b1;
        in_key = ~key;
        in_pt = ~pt;
        if (out_ct !== exp_ct || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1)
          bad_hold++;
        @(negedge clk);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      if (out_ct !== exp_ct || out_valid !== 1'b1 || in_ready !== 1'b0) bad_hold++;
      chk_i({tag, ".hold_violations"}, bad_hold, 0);
      @(negedge clk);
      out_ready = 1'b0;
      chk_v({tag, ".out_valid_drop"}, out_valid, 1'b0);
      chk_v({tag, ".in_ready_back"}, in_ready, 1'b1);
    end
  endtask

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
    int           dly;
    int           hold;
  } vec_t;

  vec_t tbl [6];

  initial begin
    logic [127:0] k2, p2, k3, p3, rk, rp;
    int t;
    k2 = 128'hfedcba98_76543210_0f1e2d3c_4b5a6978;
    p2 = 128'h13579bdf_2468ace0_deadbeef_cafef00d;
    k3 = 128'h11111111_22222222_33333333_44444444;
    p3 = 128'haaaaaaaa_bbbbbbbb_cccccccc_dddddddd;
    tbl[0] = '{FIPS_KEY, FIPS_PT, FIPS_CT, 1, 0};
    tbl[1] = '{FIPS_KEY, FIPS_PT, FIPS_CT, 3, 20};
    tbl[2] = '{k2, p2, model_ct(k2, p2), TO, 1};
    tbl[3] = '{k2, p2, 128'h0, 0, 0};
    tbl[4] = '{k3, p3, model_ct(k3, p3), 2, 0};
    tbl[5] = '{k3, p3, 128'h0, TO + 1, 0};

    // Reset state
    repeat (3) @(negedge clk);
    chk_v("rst.in_ready", in_ready, 1'b0);
    chk_v("rst.out_valid", out_valid, 1'b0);
    chk_v("rst.busy", busy, 1'b0);
    chk_v("rst.out_ct", out_ct, 128'h0);
    chk_v("rst.timeout_err", timeout_err, 1'b0);
    chk_v("rst.start_n", aes_start_n, 1'b1);
    chk_v("rst.start_read_n", aes_start_read_n, 1'b1);
    chk_v("rst.dword_in", aes_dword_in, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    chk_v("post_rst.in_ready", in_ready, 1'b1);

    for (int i = 0; i < 6; i++)
      run_block($sformatf("vec%0d", i), tbl[i].key, tbl[i].pt, tbl[i].ct, tbl[i].dly, tbl[i].hold);

    for (int i = 0; i < 20; i++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      rp = {$urandom, $urandom, $urandom, $urandom};
      run_block($sformatf("rnd%0d", i), rk, rp, model_ct(rk, rp),
                $urandom_range(1, TO), $urandom_range(0, 3));
    end

    // Reset pulse while the key words are being driven
    done_arm = 1'b0;
    in_key = k2;
    in_pt = p2;
    in_valid = 1'b1;
    t = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    while (cyc < t + 6) @(negedge clk);
    chk_v("midrst.busy_before", busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    chk_v("midrst.in_ready_during", in_ready, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_v("midrst.in_ready", in_ready, 1'b1);
    chk_v("midrst.out_valid", out_valid, 1'b0);
    chk_v("midrst.start_n", aes_start_n, 1'b1);
    chk_v("midrst.busy", busy, 1'b0);
    chk_v("midrst.out_ct", out_ct, 128'h0);
    t = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid !== 1'b0 || aes_start_read_n !== 1'b1) t++;
      @(negedge clk);
    end
    chk_i("midrst.no_activity", t, 0);
    run_block("after_rst", FIPS_KEY, FIPS_PT, FIPS_CT, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
